// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA constants, block type and unpad FSM states
package sha_pkg;

    localparam int          BLOCK_WORDS  = 16;
    localparam int          LEN_WORDS    = 2;
    localparam int          BLOCK_BITS   = 512;
    localparam int          DIGEST_WORDS = 8;
    localparam logic [31:0] PAD_MARKER   = 32'h8000_0000;

    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DRAIN,
        ST_CHECK,
        ST_FLUSH
    } unpad_state_t;

endpackage

// File: rtl/pad_check.sv
// rtl/pad_check.sv - combinational validation of the final padded block pair
module pad_check
    import sha_pkg::*;
(
    input  block_t      i_held_buf,
    input  block_t      i_final_buf,
    input  logic [15:0] i_msg_words,
    input  logic [15:0] i_blk_cnt,
    output logic        o_pass
);

    logic [31:0][31:0] w_view;
    logic [4:0]        w_pos;
    logic [16:0]       w_exp_cnt;

    assign w_view    = {i_final_buf, i_held_buf};
    // The marker only sits in the held block when the length words spill into a new block
    assign w_pos     = {(i_msg_words[3:0] <= 4'd13), i_msg_words[3:0]};
    assign w_exp_cnt = ((({1'b0, i_msg_words} + 17'd2) >> 4) + 17'd1);

    always_comb begin
        o_pass = (w_view[w_pos] == PAD_MARKER)
              && (i_final_buf[14] == 32'd0)
              && (i_final_buf[15][4:0] == 5'd0)
              && ({1'b0, i_blk_cnt} == w_exp_cnt);
        for (int j = 0; j < 30; j++) begin
            if ((5'(j) > w_pos) && (w_view[j] != 32'd0)) begin
                o_pass = 1'b0;
            end
        end
    end

endmodule

// File: rtl/unpad_block.sv
// rtl/unpad_block.sv - SHA padding remover with one-block holdback; UNPAD_CHECK_EN enables padding checks
module unpad_block
    import sha_pkg::*;
#(
    parameter int MAX_BLOCKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [15:0] msg_words,
    output logic        done,
    output logic        err
);

    unpad_state_t r_state, w_next_state;
    block_t       r_buf [2];
    logic         r_fill_sel, r_held_valid;
    logic [3:0]   r_widx;
    logic [15:0]  r_blk_cnt;
    logic [4:0]   r_oidx;
    logic [5:0]   r_rem;
    logic [15:0]  r_msg_words;
    logic         r_done, r_err;

    block_t            w_held_buf, w_final_buf;
    logic [31:0][31:0] w_view;
    logic              w_accept, w_out_hs, w_blk_end, w_overflow, w_fail;
    logic              w_set_done, w_set_err;
    logic [15:0]       w_cnt_next, w_mw, w_drained, w_diff;
    logic [5:0]        w_avail, w_rem;

    assign w_held_buf  = r_buf[~r_fill_sel];
    assign w_final_buf = r_buf[r_fill_sel];
    assign w_view      = {w_final_buf, w_held_buf};

    assign in_ready   = (r_state == ST_FILL) && !reset;
    assign out_valid  = (r_state == ST_DRAIN) || (r_state == ST_FLUSH);
    assign out_data   = out_valid ? w_view[r_oidx] : 32'd0;
    assign out_last   = (r_state == ST_FLUSH) && (r_rem == 6'd1);
    assign msg_words  = r_msg_words;
    assign done       = r_done;
    assign err        = r_err;

    assign w_accept   = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_blk_end  = w_accept && (r_widx == 4'd15);
    assign w_cnt_next = r_blk_cnt + 16'd1;
    assign w_overflow = w_cnt_next > 16'(MAX_BLOCKS);

    // Words already drained belong to blocks before the held one; only the rest remain buffered
    assign w_mw      = w_final_buf[15][20:5];
    assign w_drained = r_held_valid ? {r_blk_cnt[11:0] - 12'd2, 4'd0} : 16'd0;
    assign w_avail   = r_held_valid ? 6'd32 : 6'd16;
    assign w_diff    = w_mw - w_drained;
    assign w_rem     = (w_mw <= w_drained)             ? 6'd0    :
                       (w_diff > {10'd0, w_avail})     ? w_avail : w_diff[5:0];

`ifdef UNPAD_CHECK_EN
    logic w_pass;

    pad_check u_pad_check (
        .i_held_buf  (w_held_buf),
        .i_final_buf (w_final_buf),
        .i_msg_words (w_mw),
        .i_blk_cnt   (r_blk_cnt),
        .o_pass      (w_pass)
    );

    assign w_fail = !w_pass;
`else
    assign w_fail = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_set_done   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_blk_end) begin
                    if (w_overflow)        w_set_err = 1'b1;
                    else if (in_last)      w_next_state = ST_CHECK;
                    else if (r_held_valid) w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hs && (r_rem == 6'd1)) w_next_state = ST_FILL;
            end
            ST_CHECK: begin
                w_next_state = ST_FILL;
                if (w_fail)              w_set_err = 1'b1;
                else if (w_rem == 6'd0)  w_set_done = 1'b1;
                else                     w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_out_hs && (r_rem == 6'd1)) begin
                    w_next_state = ST_FILL;
                    w_set_done   = 1'b1;
                end
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_fill_sel   <= 1'b0;
            r_held_valid <= 1'b0;
            r_widx       <= 4'd0;
            r_blk_cnt    <= 16'd0;
            r_oidx       <= 5'd0;
            r_rem        <= 6'd0;
            r_msg_words  <= 16'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_set_done;
            r_err   <= w_set_err;
            if (w_accept) begin
                r_buf[r_fill_sel][r_widx] <= in_data;
                r_widx                    <= r_widx + 4'd1;
            end
            case (r_state)
                ST_FILL: begin
                    if (w_blk_end) begin
                        if (w_overflow) begin
                            r_held_valid <= 1'b0;
                            r_blk_cnt    <= 16'd0;
                        end else begin
                            r_blk_cnt <= w_cnt_next;
                            if (!in_last && r_held_valid) begin
                                r_oidx <= 5'd0;
                                r_rem  <= 6'd16;
                            end else if (!in_last) begin
                                r_fill_sel   <= ~r_fill_sel;
                                r_held_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_out_hs) begin
                        r_oidx <= r_oidx + 5'd1;
                        r_rem  <= r_rem - 6'd1;
                        if (r_rem == 6'd1) r_fill_sel <= ~r_fill_sel;
                    end
                end
                ST_CHECK: begin
                    r_msg_words <= w_mw;
                    r_oidx      <= r_held_valid ? 5'd0 : 5'd16;
                    r_rem       <= w_rem;
                    if (w_fail || (w_rem == 6'd0)) begin
                        r_held_valid <= 1'b0;
                        r_blk_cnt    <= 16'd0;
                    end
                end
                ST_FLUSH: begin
                    if (w_out_hs) begin
                        r_oidx <= r_oidx + 5'd1;
                        r_rem  <= r_rem - 6'd1;
                        if (r_rem == 6'd1) begin
                            r_held_valid <= 1'b0;
                            r_blk_cnt    <= 16'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/unpad_block.md
UNPAD_BLOCK -- requirements
Module: unpad_block

Interface
REQ-001 SHALL have parameter MAX_BLOCKS, default 8, the maximum number of 512-bit blocks per padded message.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, padded-word valid.
REQ-005 SHALL have port in_ready, output, 1, a word is accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, 32, padded message word, big-endian word order.
REQ-007 SHALL have port in_last, input, 1, marks word 15 of the final block.
REQ-008 SHALL have port out_valid, output, 1, recovered message word valid.
REQ-009 SHALL have port out_ready, input, 1, sink accepts when out_valid && out_ready.
REQ-010 SHALL have port out_data, output, 32, recovered message word.
REQ-011 SHALL have port out_last, output, 1, marks the final message word.
REQ-012 SHALL have port msg_words, output, 16, recovered word count, valid while done is high.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at message completion.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a malformed padding or length.

Function
REQ-015 SHALL implement states FILL, DRAIN, CHECK and FLUSH.
- FILL: in_ready=1, words are written into the fill buffer.
- DRAIN: outputs the held block.
- CHECK: one cycle, validates the final block.
- FLUSH: outputs the recovered words of the final pair.
REQ-016 SHALL use two 16-word buffers in ping-pong: the fill buffer and the held buffer.
REQ-017 SHALL keep exactly one completed non-final block held back, since padding can occupy only the last two blocks.
REQ-018 SHALL handle word 15 accepted without in_last as follows:
- if a held block exists, go to DRAIN; emit all 16 held words; swap buffers; return to FILL;
- otherwise swap buffers and stay in FILL.
REQ-019 SHALL, when word 15 is accepted with in_last, go to CHECK in the next cycle with in_ready=0.
REQ-020 SHALL compute the bit length L={word14,word15} of the final block, and set msg_words = L[20:5].
REQ-021 SHALL hold in_ready=0 in DRAIN, CHECK and FLUSH; input is not accepted until the return to FILL.
REQ-022 SHALL, in FLUSH, emit held-then-final buffer words 0..msg_words-1 in order.
- out_last is asserted with the last of these words.
- No word is emitted when msg_words=0.
REQ-023 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-024 SHALL pulse done for one cycle after the out_last handshake, or directly after CHECK when msg_words=0, then return to FILL.
REQ-025 SHALL pulse err for one cycle and discard the held and final buffers (no output) on any of:
- the block counter exceeds MAX_BLOCKS;
- a failing check under REQ-030.
It SHALL then return to FILL with done low.
REQ-026 SHALL keep words emitted before an error as emitted; there is no retraction.
REQ-027 SHALL accept an in_last on a word other than word 15 as an ordinary word, with in_last ignored.

Reset
REQ-028 SHALL, while reset is high, force:
- state FILL, buffers invalid, counters 0;
- out_valid, out_last, done, err, in_ready all 0;
- out_data and msg_words 0.
REQ-029 SHALL raise in_ready the first cycle after reset deasserts; reset mid-DRAIN or mid-FLUSH drops out_valid on the next edge, with no partial completion.

Configuration
REQ-030 With UNPAD_CHECK_EN defined, CHECK SHALL verify all of the following, and fail otherwise:
- word14 == 0 and L[4:0] == 0;
- the marker 32'h80000000 sits at word index msg_words;
- all words between the marker and word 14 are 0;
- the received block count equals floor((msg_words+2)/16)+1.
REQ-031 Without UNPAD_CHECK_EN, err SHALL be driven only by the REQ-025 block-count overflow, and padding content SHALL be ignored.

Structure
REQ-032 SHALL place the following in shared package sha_pkg, alongside other SHA constants:
- typedef block_t (32-bit x16 array);
- the state enum;
- constants PAD_MARKER=32'h80000000, BLOCK_WORDS=16, LEN_WORDS=2.
REQ-033 SHALL factor the REQ-030 checks into one combinational sub-module pad_check, taking both buffers, msg_words and the block count, and returning pass/fail.

Verification
REQ-034 One block, in_data 0xA,0xB,0xC,0x80000000,0x0 x10,0x0,0x60 with in_last -> out 0xA,0xB,0xC, out_last on 0xC, msg_words=3, done=1, err=0.
REQ-035 Fourteen words 1..14, marker at word 14 of block 0, block 1 all zero except word 15 = 0x1C0 -> 14 words out, done=1.
REQ-036 Empty message: 0x80000000, zeros, length 0 -> no out_valid, done pulse, msg_words=0.
REQ-037 UNPAD_CHECK_EN built, REQ-034 stimulus with marker 0x80000001 -> err pulse, no out_valid, no done.
REQ-038 Three-block 40-word message with out_ready toggling 1,0,0,1 -> 40 ordered words, out_data stable while stalled.
REQ-039 Reset asserted during FLUSH of REQ-035 -> out_valid=0 next cycle, in_ready=1 the cycle after release, and the REQ-034 stimulus that follows is recovered correctly.
